// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input, decode slot, status.
// Latency: n/a (wiring only).
// Backpressure: out_ready from decode stalls the slot; imem is combinational-read.
//
// Signals
//   imem_address      fetch -> imem    30  word address (pc register)
//   imem_instruction  imem  -> fetch   32  word at imem_address, same cycle
//   redirect_valid    core  -> fetch    1  branch/jump taken this cycle
//   redirect_target   core  -> fetch   30  new word PC
//   out_valid         fetch -> decode   1  slot holds an instruction
//   out_ready         decode-> fetch    1  decode accepts slot this cycle
//   out_instruction   fetch -> decode  32  fetched word
//   out_pc            fetch -> decode  32  byte address of out_instruction
//   fetch_count       fetch -> status  32  words loaded into the slot
//   fault             fetch -> status   1  sticky out-of-range fetch flag
//   fault_pc          fetch -> status  32  byte address of the faulting fetch
interface fetch_unit_if;
   logic [29:0] imem_address;
   logic [31:0] imem_instruction;
   logic        redirect_valid;
   logic [29:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic [31:0] fetch_count;
   logic        fault;
   logic [31:0] fault_pc;

   // fetch unit side
   modport master (
      output imem_address,
      input  imem_instruction,
      input  redirect_valid,
      input  redirect_target,
      output out_valid,
      input  out_ready,
      output out_instruction,
      output out_pc,
      output fetch_count,
      output fault,
      output fault_pc
   );

   // environment side (imem, redirect source, decode)
   modport slave (
      input  imem_address,
      output imem_instruction,
      output redirect_valid,
      output redirect_target,
      input  out_valid,
      output out_ready,
      input  out_instruction,
      input  out_pc,
      input  fetch_count,
      input  fault,
      input  fault_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational imem, registers word+PC into a decode slot.
// Latency: word at pc appears in the slot one edge after pc is presented; 1 word/cycle when ready.
// Backpressure: out_valid && !out_ready freezes slot, pc and count; redirect flushes regardless.
//
// Ports
//   clock   sole clock, all state updates on posedge
//   reset   asynchronous active-low reset (0 = in reset)
//   bus     fetch_unit_if.master: imem port, redirect, decode slot, fetch_count, fault status
module fetch_unit #(
   parameter logic [31:0] START_ADDR = 32'h0000_3000,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic          clock,
   input  logic          reset,
   fetch_unit_if.master  bus
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   localparam logic [29:0] START_WORD = START_ADDR[31:2];
   localparam logic [31:0] MEM_WORDS  = 32'(IMEM_WORDS);

   logic [1:0]  state;
   logic [29:0] pc;
   logic        out_valid;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic [31:0] fetch_count;
   logic        fault;
   logic [31:0] fault_pc;

   logic [29:0] pc_offset;
   logic        in_range;
   logic        slot_free;
   logic        attempt;
   logic        fire;
   logic        oor_attempt;

   // A pc below START_WORD wraps to a huge offset, so one unsigned compare
   // rejects both ends of the memory window.
   assign pc_offset = pc - START_WORD;
   assign in_range  = {2'b00, pc_offset} < MEM_WORDS;

   // A fetch is attempted whenever the slot will be free at the edge and no
   // redirect is pending; whether it loads or faults depends only on range.
   assign slot_free   = !out_valid || bus.out_ready;
   assign attempt     = (state == ST_RUN) && !bus.redirect_valid && slot_free;
   assign fire        = attempt && in_range;
   assign oor_attempt = attempt && !in_range;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= ST_BOOT;
         pc              <= START_WORD;
         out_valid       <= 1'b0;
         out_instruction <= 32'h0;
         out_pc          <= 32'h0;
         fetch_count     <= 32'h0;
         fault           <= 1'b0;
         fault_pc        <= 32'h0;
      end else begin
         case (state)
            ST_BOOT: begin
               // One idle cycle before the first fetch; a redirect still moves pc.
               state <= ST_RUN;
               if (bus.redirect_valid) begin
                  pc <= bus.redirect_target;
               end
            end

            ST_RUN: begin
               if (bus.redirect_valid) begin
                  // Redirect wins over everything: flush the slot, skip this fetch.
                  pc        <= bus.redirect_target;
                  out_valid <= 1'b0;
               end else if (fire) begin
                  out_valid       <= 1'b1;
                  out_instruction <= bus.imem_instruction;
                  out_pc          <= {pc, 2'b00};
                  pc              <= pc + 30'd1;
                  fetch_count     <= fetch_count + 32'd1;
               end else if (oor_attempt) begin
                  // Slot was free (empty or consumed this edge), so it ends empty.
                  state     <= ST_FAULT;
                  fault     <= 1'b1;
                  fault_pc  <= {pc, 2'b00};
                  out_valid <= 1'b0;
               end
               // Otherwise the slot is full and stalled: hold everything.
            end

            ST_FAULT: begin
               // Frozen until reset; only let decode drain an occupied slot.
               if (out_valid && bus.out_ready) begin
                  out_valid <= 1'b0;
               end
            end

            default: begin
               state <= ST_FAULT;
            end
         endcase
      end
   end

   // imem_address comes straight from the pc register, no input-to-output path.
   assign bus.imem_address    = pc;
   assign bus.out_valid       = out_valid;
   assign bus.out_instruction = out_instruction;
   assign bus.out_pc          = out_pc;
   assign bus.fetch_count     = fetch_count;
   assign bus.fault           = fault;
   assign bus.fault_pc        = fault_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect/reset traffic.
// Latency: outputs sampled 1ns after each posedge against a per-cycle reference model.
// Backpressure: out_ready driven randomly; model follows the documented slot rules.
module tb_fetch_unit;

   localparam logic [31:0] START_ADDR = 32'h0000_3000;
   localparam int          IMEM_WORDS = 1024;
   localparam int unsigned START_WORD = START_ADDR >> 2;

   logic clock;
   logic reset;
   logic [31:0] salt;

   fetch_unit_if bus();

   fetch_unit #(.START_ADDR(START_ADDR), .IMEM_WORDS(IMEM_WORDS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // combinational instruction memory
   assign bus.imem_instruction = {2'b00, bus.imem_address} ^ salt;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 booting, 1 running, 2 faulted
   int          m_mode;
   int unsigned m_pc;      // word PC, kept modulo 2^30
   bit          m_v;
   bit [31:0]   m_instr, m_opc, m_cnt, m_fpc;
   bit          m_fault;

   // next-state copies, computed before the edge from the presented inputs
   int          n_mode;
   int unsigned n_pc;
   bit          n_v;
   bit [31:0]   n_instr, n_opc, n_cnt, n_fpc;
   bit          n_fault;

   function automatic bit in_mem(input int unsigned w);
      longint unsigned off;
      off = (longint'(w) + (64'd1 << 30) - longint'(START_WORD)) % (64'd1 << 30);
      return off < IMEM_WORDS;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pc = START_WORD; m_v = 0; m_instr = 0; m_opc = 0;
      m_cnt = 0; m_fault = 0; m_fpc = 0;
   endtask

   task automatic model_predict();
      n_mode = m_mode; n_pc = m_pc; n_v = m_v; n_instr = m_instr; n_opc = m_opc;
      n_cnt = m_cnt; n_fault = m_fault; n_fpc = m_fpc;
      if (!reset) begin
         n_mode = 0; n_pc = START_WORD; n_v = 0; n_instr = 0; n_opc = 0;
         n_cnt = 0; n_fault = 0; n_fpc = 0;
      end else if (m_mode == 0) begin
         n_mode = 1;
         if (bus.redirect_valid) n_pc = bus.redirect_target;
      end else if (m_mode == 1) begin
         if (bus.redirect_valid) begin
            n_pc = bus.redirect_target;
            n_v  = 0;
         end else if (!m_v || bus.out_ready) begin
            if (in_mem(m_pc)) begin
               n_v     = 1;
               n_instr = (m_pc * 1) ^ salt;
               n_opc   = m_pc * 4;
               n_pc    = (m_pc + 1) % (32'd1 << 30);
               n_cnt   = m_cnt + 1;
            end else begin
               n_mode  = 2;
               n_fault = 1;
               n_fpc   = m_pc * 4;
               n_v     = 0;
            end
         end
      end else begin
         if (m_v && bus.out_ready) n_v = 0;
      end
   endtask

   task automatic compare_all(input string pfx);
      check_eq({pfx, ".valid"}, {31'b0, bus.out_valid}, {31'b0, m_v});
      check_eq({pfx, ".out_pc"}, bus.out_pc, m_opc);
      check_eq({pfx, ".instr"}, bus.out_instruction, m_instr);
      check_eq({pfx, ".count"}, bus.fetch_count, m_cnt);
      check_eq({pfx, ".fault"}, {31'b0, bus.fault}, {31'b0, m_fault});
      check_eq({pfx, ".fault_pc"}, bus.fault_pc, m_fpc);
      check_eq({pfx, ".imem_addr"}, {2'b00, bus.imem_address}, m_pc);
   endtask

   // one clock: predict, edge, commit, compare
   task automatic step(input string pfx);
      model_predict();
      @(posedge clock);
      #1;
      m_mode = n_mode; m_pc = n_pc; m_v = n_v; m_instr = n_instr; m_opc = n_opc;
      m_cnt = n_cnt; m_fault = n_fault; m_fpc = n_fpc;
      compare_all(pfx);
   endtask

   // assert reset between edges, verify immediately, then release after one edge
   task automatic pulse_reset(input string pfx);
      reset = 1'b0;
      #1;
      model_reset();
      compare_all(pfx);
      check_eq({pfx, ".addr_c00"}, {2'b00, bus.imem_address}, 32'h0000_0C00);
      step(pfx);
      reset = 1'b1;
   endtask

   initial begin
      int guard;
      bit seen_fault;
      logic [31:0] hold_pc, hold_cnt;

      reset = 1'b0;
      salt = 32'h0;
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = 30'h0;
      model_reset();
      #12;
      compare_all("reset");

      // 1: startup stream
      @(posedge clock); #1;
      reset = 1'b1;
      step("t1.e1");
      check_eq("t1.boot_idle", {31'b0, bus.out_valid}, 32'd0);
      step("t1.e2");
      check_eq("t1.first_valid", {31'b0, bus.out_valid}, 32'd1);
      check_eq("t1.pc0", bus.out_pc, 32'h3000);
      step("t1.e3");
      check_eq("t1.pc1", bus.out_pc, 32'h3004);
      step("t1.e4");
      check_eq("t1.pc2", bus.out_pc, 32'h3008);
      check_eq("t1.cnt", bus.fetch_count, 32'd3);

      // 2: stall three cycles
      bus.out_ready = 1'b0;
      hold_pc = bus.out_pc; hold_cnt = bus.fetch_count;
      for (int i = 0; i < 3; i++) step("t2.stall");
      check_eq("t2.hold_pc", bus.out_pc, hold_pc);
      check_eq("t2.hold_cnt", bus.fetch_count, hold_cnt);
      bus.out_ready = 1'b1;
      step("t2.resume");
      check_eq("t2.next_pc", bus.out_pc, hold_pc + 32'd4);

      // 3: redirect while stalled
      bus.out_ready = 1'b0;
      step("t3.fill");
      hold_cnt = bus.fetch_count;
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 30'(32'h3100 >> 2);
      step("t3.flush");
      check_eq("t3.flushed", {31'b0, bus.out_valid}, 32'd0);
      check_eq("t3.addr", {2'b00, bus.imem_address}, 32'h0000_0C40);
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      step("t3.land");
      check_eq("t3.out_pc", bus.out_pc, 32'h3100);
      check_eq("t3.cnt", bus.fetch_count, hold_cnt + 32'd1);

      // 4: run off the end of memory
      salt = 32'h5A5A_0000;
      guard = 0;
      while (!m_fault && guard < 1500) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step("t4.run");
         guard++;
      end
      check_eq("t4.reached_fault", {31'b0, m_fault}, 32'd1);
      check_eq("t4.fault_pc", bus.fault_pc, 32'h4000);
      check_eq("t4.last_word", bus.out_pc, 32'h3FFC);
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 30'(32'h3000 >> 2);
      step("t4.redir_ignored");
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) step("t4.frozen");
      check_eq("t4.no_valid", {31'b0, bus.out_valid}, 32'd0);

      // 5: redirect below memory
      pulse_reset("t5.rst");
      step("t5.boot");
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 30'(32'h2FFC >> 2);
      step("t5.redir");
      bus.redirect_valid = 1'b0;
      step("t5.attempt");
      check_eq("t5.fault", {31'b0, bus.fault}, 32'd1);
      check_eq("t5.fault_pc", bus.fault_pc, 32'h2FFC);

      // 6: reset mid-stream
      pulse_reset("t6.rst0");
      for (int i = 0; i < 6; i++) step("t6.stream");
      pulse_reset("t6.rst");
      step("t6.boot");
      step("t6.first");
      check_eq("t6.restart_pc", bus.out_pc, 32'h3000);

      // random traffic
      seen_fault = 0;
      for (int i = 0; i < 4000; i++) begin
         int unsigned r;
         r = $urandom_range(0, 199);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = 1'b0;
         salt = $urandom;
         if (r < 8) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_target = 30'(START_WORD + $urandom_range(0, IMEM_WORDS - 1));
         end else if (r < 12) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_target = 30'(START_WORD + IMEM_WORDS - $urandom_range(1, 6));
         end else if (r == 12) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_target = 30'($urandom);
         end else if (r == 13 || (m_fault && r < 40)) begin
            if (m_fault) seen_fault = 1;
            pulse_reset("rnd.rst");
            continue;
         end
         step("rnd");
      end
      check_eq("rnd.saw_fault", {31'b0, seen_fault}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
